// File: rtl/fp_divsqrt_iter.sv
// fp_divsqrt_iter
// Iterative floating-point divide / square-root unit. Radix-2 restoring
// iteration produces one quotient/root bit per cycle, followed by a single
// round-to-nearest-even cycle. Subnormal operands and results flush to zero.
// IEEE special operands bypass the iteration and finish in one cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (ready only while idle)
//   in_op               0 = divide in_a/in_b, 1 = square root of in_a
//   in_a, in_b          packed operands {sign, exponent, fraction}
//   out_valid/out_ready result handshake; result held until accepted
//   out_result          packed result
//   out_flags           {invalid, div_by_zero, overflow, underflow, inexact}
//
// Build option: FDGA_FP_FLAGS_EN enables the exception flags; without it
// out_flags is tied to zero and the results are unchanged.

module fp_divsqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [4:0]           out_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 3;
    localparam int SW = MAN_W + 1;
    localparam int RW = N + 3;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(N);

    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_ALL1 = XW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0]        LAST     = CW'(N - 1);
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

    state_t state, state_next;

    logic                 op_r;
    logic                 sign_r;
    logic signed [XW-1:0] exp_r;
    logic [SW-1:0]        divisor;
    logic [2*N-1:0]       rad;
    logic [RW-1:0]        rem;
    logic [N-1:0]         q;
    logic [CW-1:0]        count;

    // Operand unpacking; an exponent field of zero is treated as zero.
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {a_sign, a_exp, a_frac} = in_a;
    assign {b_sign, b_exp, b_frac} = in_b;
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_frac == '0);
    assign b_inf  = (&b_exp) && (b_frac == '0);
    assign a_nan  = (&a_exp) && (a_frac != '0);
    assign b_nan  = (&b_exp) && (b_frac != '0);

    logic accept;
    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Special operands resolve directly to a packed result.
    logic         spec_hit;
    logic [W-1:0] spec_result;
    logic         q_sign;

    assign q_sign = a_sign ^ b_sign;

    always_comb begin
        spec_hit    = 1'b1;
        spec_result = '0;
        if (!in_op) begin
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
                spec_result = QNAN;
            else if (a_inf || b_zero)
                spec_result = {q_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (a_zero || b_inf)
                spec_result = {q_sign, {(W-1){1'b0}}};
            else
                spec_hit = 1'b0;
        end else begin
            if (a_nan)
                spec_result = QNAN;
            else if (a_zero)
                spec_result = {a_sign, {(W-1){1'b0}}};
            else if (a_sign)
                spec_result = QNAN;
            else if (a_inf)
                spec_result = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                spec_hit = 1'b0;
        end
    end

    // Starting exponent and radicand alignment. An odd unbiased exponent is
    // made even by doubling the radicand so the halving is exact.
    logic [SW-1:0]        a_sig, b_sig;
    logic signed [XW-1:0] div_exp, sq_unb, sq_adj, sq_exp;
    logic                 sq_odd;
    logic [SW:0]          sq_rad;

    assign a_sig   = {1'b1, a_frac};
    assign b_sig   = {1'b1, b_frac};
    assign div_exp = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
    assign sq_unb  = $signed({2'b00, a_exp}) - BIAS;
    assign sq_odd  = sq_unb[0];
    assign sq_adj  = sq_odd ? sq_unb - XW'(1) : sq_unb;
    assign sq_exp  = (sq_adj >>> 1) + BIAS;
    assign sq_rad  = sq_odd ? {a_sig, 1'b0} : {1'b0, a_sig};

    // One restoring step. Division compares the remainder with the divisor
    // and doubles it afterwards; square root brings down two radicand bits
    // and compares with the partial root extended by 01.
    logic [RW-1:0] rem_in, trial, diff, rem_next;
    logic          ge;

    always_comb begin
        rem_in   = op_r ? {rem[RW-3:0], rad[2*N-1:2*N-2]} : rem;
        trial    = op_r ? {1'b0, q, 2'b01} : {{(RW-SW){1'b0}}, divisor};
        ge       = (rem_in >= trial);
        diff     = ge ? rem_in - trial : rem_in;
        rem_next = op_r ? diff : {diff[RW-2:0], 1'b0};
    end

    // Rounding. A quotient below one is normalised by one place, which moves
    // the guard bit down and leaves only the remainder for the sticky bit.
    logic                 norm, guard, sticky, round_up, ovf, unf;
    logic [MAN_W-1:0]     r_frac;
    logic [MAN_W:0]       frac_sum;
    logic signed [XW-1:0] r_exp, fin_exp;
    logic [W-1:0]         rnd_result;

    always_comb begin
        norm     = q[N-1];
        r_frac   = norm ? q[N-2:2] : q[N-3:1];
        guard    = norm ? q[1] : q[0];
        sticky   = (norm && q[0]) || (rem != '0);
        r_exp    = norm ? exp_r : exp_r - XW'(1);
        round_up = guard && (sticky || r_frac[0]);
        frac_sum = {1'b0, r_frac} + {{MAN_W{1'b0}}, round_up};
        fin_exp  = r_exp + {{(XW-1){1'b0}}, frac_sum[MAN_W]};
        ovf      = (fin_exp >= EXP_ALL1);
        unf      = fin_exp[XW-1] || (fin_exp == '0);
        if (ovf)
            rnd_result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
            rnd_result = {sign_r, {(W-1){1'b0}}};
        else
            rnd_result = {sign_r, fin_exp[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = spec_hit ? DONE : ITER;
            ITER:  if (count == LAST) state_next = ROUND;
            ROUND: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r       <= 1'b0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            divisor    <= '0;
            rad        <= '0;
            rem        <= '0;
            q          <= '0;
            count      <= '0;
            out_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r    <= in_op;
                        sign_r  <= in_op ? 1'b0 : q_sign;
                        exp_r   <= in_op ? sq_exp : div_exp;
                        divisor <= b_sig;
                        rad     <= {sq_rad, {(MAN_W+4){1'b0}}};
                        rem     <= in_op ? '0 : {{(RW-SW){1'b0}}, a_sig};
                        q       <= '0;
                        count   <= '0;
                        if (spec_hit)
                            out_result <= spec_result;
                    end
                end
                ITER: begin
                    rem   <= rem_next;
                    q     <= {q[N-2:0], ge};
                    rad   <= {rad[2*N-3:0], 2'b00};
                    count <= (count == LAST) ? '0 : count + CW'(1);
                end
                ROUND: out_result <= rnd_result;
                default: ;
            endcase
        end
    end

`ifdef FDGA_FP_FLAGS_EN
    logic [4:0] spec_flags, rnd_flags, flags_q;
    logic       div_invalid, sqrt_invalid, div_zero;

    assign div_invalid  = !in_op && !(a_nan || b_nan) &&
                          ((a_zero && b_zero) || (a_inf && b_inf));
    assign sqrt_invalid = in_op && !a_nan && !a_zero && a_sign;
    assign div_zero     = !in_op && !(a_nan || b_nan) && !a_inf && !a_zero && b_zero;
    assign spec_flags   = {div_invalid || sqrt_invalid, div_zero, 3'b000};
    assign rnd_flags    = ovf ? 5'b00101 :
                          unf ? 5'b00011 : {4'b0000, guard || sticky};

    // Flags are registered alongside the result they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flags_q <= '0;
        else if (accept && spec_hit)
            flags_q <= spec_flags;
        else if (state == ROUND)
            flags_q <= rnd_flags;
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 5'b00000;
`endif

endmodule
